// File: rtl/uart_transmitter_if.sv
// Bundles the byte-write, baud-tick and serial-line signals of the UART transmitter.
//   clk_en   : baud tick at OVERSAMPLE x baud rate (master drives)
//   wr_en    : FIFO write strobe (master drives)
//   wr_data  : byte to queue (master drives)
//   full     : FIFO holds FIFO_DEPTH entries
//   empty    : FIFO holds zero entries
//   overflow : one-cycle pulse when a write is rejected
//   tx       : serial line, 8N1, idle high
//   busy     : serializer is mid-frame
//   tx_done  : one-cycle pulse at the end of each stop bit
interface uart_transmitter_if;
   logic       clk_en;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       full;
   logic       empty;
   logic       overflow;
   logic       tx;
   logic       busy;
   logic       tx_done;

   modport master (
      output clk_en, wr_en, wr_data,
      input  full, empty, overflow, tx, busy, tx_done
   );

   modport slave (
      input  clk_en, wr_en, wr_data,
      output full, empty, overflow, tx, busy, tx_done
   );
endinterface

// File: rtl/uart_transmitter.sv
// UART transmitter: small byte FIFO feeding an 8N1 serializer clocked by a baud tick.
//   clk_in : system clock, rising edge
//   reset  : asynchronous, active-high
//   bus    : uart_transmitter_if.slave (clk_en, wr_en, wr_data in; full, empty, overflow,
//            tx, busy, tx_done out)
module uart_transmitter #(
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic              clk_in,
   input  logic              reset,
   uart_transmitter_if.slave bus
);

   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e          state_q, state_d;
   logic [TW-1:0]   tick_q, tick_d;
   logic [3:0]      bit_q, bit_d;
   logic [7:0]      shreg_q, shreg_d;
   logic            tx_q, tx_d;
   logic            tx_done_q, tx_done_d;
   logic            overflow_q;

   logic [7:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [AW:0]     count_q, count_d;
   logic            full_q, empty_q;
   logic            push, pop;
   logic [7:0]      head;

   assign head = mem[rd_ptr_q];
   // A write is judged against the registered full flag, so a same-cycle pop cannot rescue it.
   assign push = bus.wr_en && !full_q;

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end
   end

   always_comb begin
      state_d   = state_q;
      tick_d    = tick_q;
      bit_d     = bit_q;
      shreg_d   = shreg_q;
      tx_d      = tx_q;
      tx_done_d = 1'b0;
      pop       = 1'b0;
      if (bus.clk_en) begin
         case (state_q)
            StIdle: begin
               tx_d = 1'b1;
               if (!empty_q) begin
                  pop     = 1'b1;
                  shreg_d = head;
                  tick_d  = '0;
                  bit_d   = '0;
                  state_d = StStart;
                  tx_d    = 1'b0;
               end
            end
            StStart: begin
               if (tick_q == TICK_LAST) begin
                  tick_d  = '0;
                  state_d = StData;
                  tx_d    = shreg_q[0];
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
            StData: begin
               if (tick_q == TICK_LAST) begin
                  tick_d  = '0;
                  shreg_d = {1'b0, shreg_q[7:1]};
                  if (bit_q == 4'd7) begin
                     bit_d   = '0;
                     state_d = StStop;
                     tx_d    = 1'b1;
                  end else begin
                     bit_d = bit_q + 4'd1;
                     tx_d  = shreg_q[1];
                  end
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
            StStop: begin
               if (tick_q == TICK_LAST) begin
                  tx_done_d = 1'b1;
                  tick_d    = '0;
                  // Chain straight into the next frame when more data is queued.
                  if (!empty_q) begin
                     pop     = 1'b1;
                     shreg_d = head;
                     bit_d   = '0;
                     state_d = StStart;
                     tx_d    = 1'b0;
                  end else begin
                     state_d = StIdle;
                     tx_d    = 1'b1;
                  end
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
            default: begin
               state_d = StIdle;
               tx_d    = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         tick_q     <= '0;
         bit_q      <= '0;
         shreg_q    <= '0;
         tx_q       <= 1'b1;
         tx_done_q  <= 1'b0;
         overflow_q <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
      end else begin
         state_q    <= state_d;
         tick_q     <= tick_d;
         bit_q      <= bit_d;
         shreg_q    <= shreg_d;
         tx_q       <= tx_d;
         tx_done_q  <= tx_done_d;
         overflow_q <= bus.wr_en && full_q;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         count_q <= count_d;
         full_q  <= (count_d == DEPTH_CNT);
         empty_q <= (count_d == '0);
      end
   end

   // Storage needs no reset: the pointers and count define which entries are valid.
   always_ff @(posedge clk_in) begin
      if (push) begin
         mem[wr_ptr_q] <= bus.wr_data;
      end
   end

   assign bus.full     = full_q;
   assign bus.empty    = empty_q;
   assign bus.overflow = overflow_q;
   assign bus.tx       = tx_q;
   assign bus.busy     = (state_q != StIdle);
   assign bus.tx_done  = tx_done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: table of single-frame vectors, hand-written
// corner sequences, and a randomized phase, all checked against a cycle-level reference
// model built from a byte queue and an enabled-tick index into the 10-bit frame.
module tb_uart_transmitter;

   localparam int OS    = 16;
   localparam int DEPTH = 4;
   localparam int FRAME = 10 * OS;

   logic clk;
   logic reset;
   uart_transmitter_if bif ();

   uart_transmitter #(
      .OVERSAMPLE(OS),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk_in(clk),
      .reset (reset),
      .bus   (bif)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   logic [7:0] m_q[$];
   logic       m_active = 1'b0;
   int         m_idx = 0;
   logic [7:0] m_byte = 8'h00;
   logic [9:0] cap_frame = '1;
   logic [9:0] cap_q[$];
   int         done_seen = 0;
   int         busy_ticks = 0;
   int         en_period = 1;

   typedef struct {
      logic [7:0] data;
      int         period;
      logic [9:0] frame;
   } vec_t;
   vec_t tbl[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic line_bit(input logic [7:0] b, input int idx);
      int seg;
      seg = idx / OS;
      if (seg == 0) return 1'b0;
      if (seg == 9) return 1'b1;
      return b[seg-1];
   endfunction

   task automatic tick_wait();
      @(negedge clk);
      #1;
   endtask

   task automatic write_byte(input logic [7:0] d);
      bif.wr_en   = 1'b1;
      bif.wr_data = d;
      tick_wait();
      bif.wr_en   = 1'b0;
   endtask

   task automatic wait_idle(input int limit);
      int c;
      c = 0;
      while (c < limit && (m_active || m_q.size() != 0 || bif.busy)) begin
         tick_wait();
         c++;
      end
      check("idle_timeout", 32'(c < limit), 32'd1);
   endtask

   task automatic wait_frames(input int n, input int limit);
      int c;
      c = 0;
      while (c < limit && cap_q.size() < n) begin
         tick_wait();
         c++;
      end
      check("frame_timeout", 32'(cap_q.size() >= n), 32'd1);
   endtask

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Baud tick: one enabled edge every en_period clocks, or none when en_period is 0.
   initial begin
      int en_cnt;
      en_cnt = 0;
      bif.clk_en = 1'b0;
      forever begin
         @(negedge clk);
         if (en_period == 0) begin
            bif.clk_en = 1'b0;
            en_cnt = 0;
         end else begin
            en_cnt++;
            if (en_cnt >= en_period) begin
               bif.clk_en = 1'b1;
               en_cnt = 0;
            end else begin
               bif.clk_en = 1'b0;
            end
         end
      end
   end

   // Reference model and per-edge comparison
   initial begin
      logic       en_s, wr_s, rst_s;
      logic [7:0] wd_s;
      logic       e_tx, e_busy, e_done, e_ovf;
      int         cnt_b;
      forever begin
         @(posedge clk);
         en_s  = bif.clk_en;
         wr_s  = bif.wr_en;
         wd_s  = bif.wr_data;
         rst_s = reset;
         #1;
         e_done = 1'b0;
         e_ovf  = 1'b0;
         if (rst_s) begin
            m_q.delete();
            m_active = 1'b0;
            m_idx    = 0;
         end else begin
            cnt_b = m_q.size();
            e_ovf = wr_s && (cnt_b == DEPTH);
            if (en_s) begin
               if (m_active) begin
                  if (m_idx == FRAME - 1) begin
                     e_done   = 1'b1;
                     m_active = 1'b0;
                     cap_q.push_back(cap_frame);
                     check("frame_bits", 32'(cap_frame), 32'({1'b1, m_byte, 1'b0}));
                  end else begin
                     m_idx++;
                  end
               end
               if (!m_active && cnt_b > 0) begin
                  m_byte    = m_q.pop_front();
                  m_active  = 1'b1;
                  m_idx     = 0;
                  cap_frame = '1;
               end
            end
            if (wr_s && cnt_b < DEPTH) m_q.push_back(wd_s);
         end
         e_tx   = m_active ? line_bit(m_byte, m_idx) : 1'b1;
         e_busy = m_active;
         check("tx", 32'(bif.tx), 32'(e_tx));
         check("busy", 32'(bif.busy), 32'(e_busy));
         check("tx_done", 32'(bif.tx_done), 32'(e_done));
         check("overflow", 32'(bif.overflow), 32'(e_ovf));
         check("full", 32'(bif.full), 32'(m_q.size() == DEPTH));
         check("empty", 32'(bif.empty), 32'(m_q.size() == 0));
         if (en_s && !rst_s && m_active && (m_idx % OS) == OS / 2) cap_frame[m_idx / OS] = bif.tx;
         if (bif.tx_done) done_seen++;
         if (en_s && bif.busy) busy_ticks++;
      end
   end

   // Hard stop in case something wedges the sequences below
   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout expected completion");
      n_errors++;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $fatal(1);
   end

   initial begin
      int d0;
      tbl[0] = '{data: 8'hA5, period: 4, frame: 10'h34A};
      tbl[1] = '{data: 8'h00, period: 1, frame: 10'h200};
      tbl[2] = '{data: 8'hFF, period: 2, frame: 10'h3FE};
      tbl[3] = '{data: 8'h55, period: 3, frame: 10'h2AA};
      tbl[4] = '{data: 8'h01, period: 1, frame: 10'h202};
      tbl[5] = '{data: 8'h80, period: 2, frame: 10'h300};

      reset       = 1'b0;
      bif.wr_en   = 1'b0;
      bif.wr_data = 8'h00;
      #2 reset = 1'b1;
      #1;
      check("rst_tx", 32'(bif.tx), 32'd1);
      check("rst_busy", 32'(bif.busy), 32'd0);
      check("rst_empty", 32'(bif.empty), 32'd1);
      check("rst_full", 32'(bif.full), 32'd0);
      check("rst_overflow", 32'(bif.overflow), 32'd0);
      check("rst_tx_done", 32'(bif.tx_done), 32'd0);
      repeat (3) tick_wait();
      reset = 1'b0;
      repeat (4) tick_wait();

      // Single frames from the vector table
      for (int i = 0; i < 6; i++) begin
         en_period = tbl[i].period;
         cap_q.delete();
         repeat (2) tick_wait();
         d0 = done_seen;
         write_byte(tbl[i].data);
         wait_frames(1, FRAME * (tbl[i].period + 1) + 50);
         if (cap_q.size() > 0) check("tbl_frame", 32'(cap_q[0]), 32'(tbl[i].frame));
         wait_idle(100);
         check("tbl_done_count", done_seen - d0, 32'd1);
         check("tbl_busy_after", 32'(bif.busy), 32'd0);
      end

      // Three back-to-back frames, no idle gap
      en_period = 2;
      cap_q.delete();
      repeat (2) tick_wait();
      busy_ticks = 0;
      d0 = done_seen;
      bif.wr_en = 1'b1;
      bif.wr_data = 8'h00; tick_wait();
      bif.wr_data = 8'hFF; tick_wait();
      bif.wr_data = 8'h55; tick_wait();
      bif.wr_en = 1'b0;
      wait_idle(3 * FRAME * 3 + 100);
      check("b2b_ticks", busy_ticks, 32'd480);
      check("b2b_done_count", done_seen - d0, 32'd3);
      if (cap_q.size() == 3) begin
         check("b2b_frame0", 32'(cap_q[0]), 32'h200);
         check("b2b_frame1", 32'(cap_q[1]), 32'h3FE);
         check("b2b_frame2", 32'(cap_q[2]), 32'h2AA);
      end else begin
         check("b2b_frame_count", cap_q.size(), 32'd3);
      end

      // Fill with baud tick held low, overflow on the fifth write
      en_period = 0;
      cap_q.delete();
      repeat (2) tick_wait();
      for (int k = 0; k < 5; k++) begin
         bif.wr_en   = 1'b1;
         bif.wr_data = 8'(8'h11 * (k + 1));
         tick_wait();
         if (k == 2) check("fill_not_full", 32'(bif.full), 32'd0);
         if (k == 3) check("fill_full", 32'(bif.full), 32'd1);
         if (k == 4) check("fill_overflow", 32'(bif.overflow), 32'd1);
      end
      bif.wr_en = 1'b0;
      tick_wait();
      check("overflow_pulse", 32'(bif.overflow), 32'd0);
      check("hold_idle_busy", 32'(bif.busy), 32'd0);
      en_period = 1;
      wait_frames(4, 4 * FRAME + 100);
      if (cap_q.size() >= 4) begin
         check("fill_frame0", 32'(cap_q[0]), 32'h222);
         check("fill_frame1", 32'(cap_q[1]), 32'h244);
         check("fill_frame2", 32'(cap_q[2]), 32'h266);
         check("fill_frame3", 32'(cap_q[3]), 32'h288);
      end
      wait_idle(200);
      check("fill_no_fifth", cap_q.size(), 32'd4);

      // Write lands on the edge that pops the last queued byte at stop end
      en_period = 1;
      cap_q.delete();
      repeat (2) tick_wait();
      write_byte(8'h3C);
      write_byte(8'hC3);
      begin
         int c;
         c = 0;
         while (c < 2 * FRAME && !(m_active && m_idx == FRAME - 1 && m_byte == 8'h3C)) begin
            tick_wait();
            c++;
         end
         check("seam_reached", 32'(c < 2 * FRAME), 32'd1);
      end
      write_byte(8'h96);
      check("seam_empty", 32'(bif.empty), 32'd0);
      check("seam_full", 32'(bif.full), 32'd0);
      wait_frames(3, 3 * FRAME + 100);
      if (cap_q.size() >= 3) begin
         check("seam_frame0", 32'(cap_q[0]), 32'h278);
         check("seam_frame1", 32'(cap_q[1]), 32'h386);
         check("seam_frame2", 32'(cap_q[2]), 32'h32C);
      end
      wait_idle(100);

      // Reset at tick 70 of a frame with another byte queued
      en_period = 1;
      cap_q.delete();
      repeat (2) tick_wait();
      write_byte(8'h5A);
      write_byte(8'hA5);
      begin
         int c;
         c = 0;
         while (c < 2 * FRAME && !(m_active && m_idx == 70)) begin
            tick_wait();
            c++;
         end
         check("abort_reached", 32'(c < 2 * FRAME), 32'd1);
      end
      d0 = done_seen;
      reset = 1'b1;
      #1;
      check("abort_tx", 32'(bif.tx), 32'd1);
      check("abort_busy", 32'(bif.busy), 32'd0);
      check("abort_empty", 32'(bif.empty), 32'd1);
      check("abort_tx_done", 32'(bif.tx_done), 32'd0);
      repeat (2) tick_wait();
      reset = 1'b0;
      repeat (2 * FRAME) tick_wait();
      check("abort_no_restart", 32'(bif.busy), 32'd0);
      check("abort_no_done", done_seen - d0, 32'd0);
      check("abort_no_frame", cap_q.size(), 32'd0);

      // Randomized traffic against the model
      for (int c = 0; c < 4000; c++) begin
         if (c % 250 == 0) en_period = int'($urandom_range(1, 3));
         bif.wr_en   = ($urandom_range(0, 5) == 0);
         bif.wr_data = 8'($urandom);
         tick_wait();
      end
      bif.wr_en = 1'b0;
      wait_idle((DEPTH + 1) * FRAME * 3 + 100);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
